// File: rtl/demux_pkg.sv
// ============================================================================
//  Module   : demux_pkg
//  Brief    : Shared state encoding and counter width for the 1-to-2 stream demux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_A     = 2'd1,
      ST_B     = 2'd2
   } state_t;

   localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/demux1to2_slice.sv
// ============================================================================
//  Module   : demux1to2_slice
//  Brief    : Combinational 1-bit steer: d goes to ya when sel=0, to yb when sel=1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux1to2_slice (
   input  logic d,
   input  logic sel,
   output logic ya,
   output logic yb
);

   assign ya = d & ~sel;
   assign yb = d &  sel;

endmodule

`default_nettype wire

// File: rtl/demux1to2_nbit_stream.sv
// ============================================================================
//  Module   : demux1to2_nbit_stream
//  Brief    : Registered 1-to-2 valid/ready stream demux with a single-entry
//             output stage. Define DEMUX_CNT_EN to add saturating per-port
//             transfer counters (cnt_a, cnt_b).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux1to2_nbit_stream
   import demux_pkg::*;
#(
   parameter int N = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             s,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [N-1:0]     a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [N-1:0]     b_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
`endif
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [N-1:0] r_data;
   logic         w_in_xfer;
   logic         w_sel;
   logic         w_busy;
   logic [N-1:0] w_ya;
   logic [N-1:0] w_yb;

   // Ready depends only on the held word's consumer, never on in_valid/in_data/s.
   assign in_ready  = rst_n & ((r_state == ST_EMPTY) |
                               ((r_state == ST_A) & a_ready) |
                               ((r_state == ST_B) & b_ready));
   assign w_in_xfer = in_valid & in_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: w_state_nxt = ST_EMPTY;
         ST_A:     if (a_ready) w_state_nxt = ST_EMPTY;
         ST_B:     if (b_ready) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
      if (w_in_xfer) begin
         w_state_nxt = s ? ST_B : ST_A;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_xfer) begin
            r_data <= in_data;
         end
      end
   end

   assign w_sel  = (r_state == ST_B);
   assign w_busy = (r_state == ST_A) | (r_state == ST_B);

   for (genvar i = 0; i < N; i++) begin : g_slice
      demux1to2_slice u_slice (
         .d   (r_data[i]),
         .sel (w_sel),
         .ya  (w_ya[i]),
         .yb  (w_yb[i])
      );
   end

   // Gating keeps an idle port at zero rather than showing the last word.
   assign a_data  = w_ya & {N{w_busy}};
   assign b_data  = w_yb & {N{w_busy}};
   assign a_valid = (r_state == ST_A);
   assign b_valid = (r_state == ST_B);

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_a <= '0;
         r_cnt_b <= '0;
      end else begin
         if (a_valid && a_ready && (r_cnt_a != {CNT_W{1'b1}})) begin
            r_cnt_a <= r_cnt_a + 1'b1;
         end
         if (b_valid && b_ready && (r_cnt_b != {CNT_W{1'b1}})) begin
            r_cnt_b <= r_cnt_b + 1'b1;
         end
      end
   end

   assign cnt_a = r_cnt_a;
   assign cnt_b = r_cnt_b;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux1to2_nbit_stream.sv
// ============================================================================
//  Module   : tb_demux1to2_nbit_stream
//  Brief    : Self-checking bench for demux1to2_nbit_stream (N=8), directed
//             scenarios plus randomized traffic against a word-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux1to2_nbit_stream;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_data = '0;
   logic         s = 1'b0;
   logic         a_valid;
   logic         a_ready = 1'b0;
   logic [N-1:0] a_data;
   logic         b_valid;
   logic         b_ready = 1'b0;
   logic [N-1:0] b_data;
`ifdef DEMUX_CNT_EN
   logic [15:0]  cnt_a;
   logic [15:0]  cnt_b;
`endif

   demux1to2_nbit_stream #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .s        (s),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data)
`ifdef DEMUX_CNT_EN
      ,
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Word-level model: at most one word in flight, plus per-port expected order.
   bit           m_held = 0;
   bit           m_dest = 0;
   logic [N-1:0] m_word = '0;
   logic [N-1:0] qa[$];
   logic [N-1:0] qb[$];
   int           m_cnt_a = 0;
   int           m_cnt_b = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_held = 0;
      qa.delete();
      qb.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
   endtask

   task automatic step(input bit v, input bit sel, input logic [N-1:0] d,
                       input bit ar, input bit br);
      bit exp_rdy;
      bit drain;
      @(negedge clk);
      in_valid = v;
      s        = sel;
      in_data  = d;
      a_ready  = ar;
      b_ready  = br;
      #1;
      exp_rdy = !m_held || (m_dest ? br : ar);
      drain   = m_held && (m_dest ? br : ar);
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("a_valid", {31'b0, a_valid}, {31'b0, m_held && !m_dest});
      chk("b_valid", {31'b0, b_valid}, {31'b0, m_held && m_dest});
      chk("a_data", {24'b0, a_data}, {24'b0, (m_held && !m_dest) ? m_word : 8'h00});
      chk("b_data", {24'b0, b_data}, {24'b0, (m_held && m_dest) ? m_word : 8'h00});
      if (a_valid && a_ready) begin
         if (qa.size() == 0) chk("a_spurious", 32'd1, 32'd0);
         else chk("a_order", {24'b0, a_data}, {24'b0, qa.pop_front()});
      end
      if (b_valid && b_ready) begin
         if (qb.size() == 0) chk("b_spurious", 32'd1, 32'd0);
         else chk("b_order", {24'b0, b_data}, {24'b0, qb.pop_front()});
      end
`ifdef DEMUX_CNT_EN
      chk("cnt_a", {16'b0, cnt_a}, m_cnt_a);
      chk("cnt_b", {16'b0, cnt_b}, m_cnt_b);
`endif
      @(posedge clk);
      if (drain) begin
         m_held = 0;
         if (m_dest) m_cnt_b = (m_cnt_b < 65535) ? m_cnt_b + 1 : 65535;
         else        m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
      end
      if (v && exp_rdy) begin
         m_held = 1;
         m_dest = sel;
         m_word = d;
         if (sel) qb.push_back(d);
         else     qa.push_back(d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Single word to B
      step(1, 1, 8'hA5, 1, 1);
      step(0, 0, 8'h00, 1, 1);
      step(0, 0, 8'h00, 1, 1);

      // Backpressure on A with b_ready toggling
      step(1, 0, 8'h3C, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 8'hEE, 0, i[0]);
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 1);

      // Alternating back-to-back stream
      for (int i = 0; i < 8; i++) step(1, i[0], 8'(i), 1, 1);
      step(0, 0, 8'h00, 1, 1);
      step(0, 0, 8'h00, 1, 1);

      // Drain B and load A in the same cycle
      step(1, 1, 8'h55, 1, 1);
      step(1, 0, 8'h11, 1, 1);
      step(0, 0, 8'h00, 0, 1);
      step(0, 0, 8'h00, 1, 1);

      // Asynchronous reset while holding a word for A
      step(1, 0, 8'h77, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_a_valid", {31'b0, a_valid}, 32'd0);
      chk("arst_b_valid", {31'b0, b_valid}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("arst_a_data", {24'b0, a_data}, 32'd0);
      chk("arst_b_data", {24'b0, b_data}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, 1'($urandom), 8'($urandom),
              ($urandom % 3) != 0, ($urandom % 3) != 0);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 1);
      chk("a_queue_empty", qa.size(), 32'd0);
      chk("b_queue_empty", qb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/demux1to2_nbit_stream.md
# demux1to2_Nbit_stream

Registered 1-to-2 stream demultiplexer: accepts an N-bit word with a valid/ready handshake and a per-word select, holds it in a single-entry output stage, and presents it on exactly one of two output ports. It is the steering counterpart to the team's N-bit 2-to-1 mux and sits wherever one producer feeds two consumers, for example splitting a datapath result between two downstream units. Full throughput (one word per cycle) while the selected consumer keeps ready high.

## Interface
Parameters:
- N, default 1: data width in bits, N ≥ 1.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  N  upstream word
- s  in  1  destination of the current word: 0 → port A, 1 → port B; sampled with in_data
- a_valid  out  1  port A word valid
- a_ready  in  1  port A consumer ready
- a_data  out  N  port A word
- b_valid  out  1  port B word valid
- b_ready  in  1  port B consumer ready
- b_data  out  N  port B word

## Operation
- State machine, states ST_EMPTY, ST_A, ST_B (held word destined for A or B).
- Transfer rule on every port: a transfer occurs when valid and ready are both high at a rising edge.
- in_ready = rst_n & (state == ST_EMPTY | (state == ST_A & a_ready) | (state == ST_B & b_ready)). Combinational from a_ready/b_ready; no combinational path from in_valid, in_data or s.
- On an input transfer, data_q ← in_data; next state ← ST_A if s = 0, else ST_B.
- ST_EMPTY: input transfer → ST_A or ST_B, else stay.
- ST_A: a_ready high and no input transfer → ST_EMPTY. a_ready high with a simultaneous input transfer → drain and reload in the same cycle, next state set by the new s. a_ready low → hold; in_ready = 0. b_ready is ignored.
- ST_B: mirror image of ST_A, using b_ready.
- Outputs: a_valid = (state == ST_A); b_valid = (state == ST_B). a_data = data_q when state == ST_A, else all zeros; b_data likewise for ST_B. An idle port never shows stale data.
- s, in_data and in_valid are don't-care when no input transfer occurs.
- Once valid, a held word and its destination stay stable until the word is consumed.

## Timing
- Latency: a word accepted at edge k appears valid on its port immediately after edge k and is consumed at the first later edge where that port's ready is high.
- Throughput: one word per cycle, including back-to-back words that alternate between A and B, as long as the destination of the held word is ready.
- Reset (rst_n low, any time, including mid-transfer): state → ST_EMPTY, data_q → 0 immediately. While rst_n is low: a_valid = b_valid = 0, a_data = b_data = 0, in_ready = 0. A held word is discarded.
- First input transfer is possible at the first rising edge after rst_n goes high.

## Configuration
- DEMUX_CNT_EN defined: adds output ports cnt_a and cnt_b, each CNT_W bits wide. They count completed transfers on port A and port B respectively.
  - The counters saturate at all-ones.
  - They reset to 0 asynchronously with rst_n.
  - Both increment in the same cycle as the corresponding output transfer.
- DEMUX_CNT_EN undefined: the ports and the counter logic are absent. Behaviour is otherwise identical.

## Structure
- Package demux_pkg holds:
  - typedef enum logic [1:0] state_t {ST_EMPTY, ST_A, ST_B};
  - localparam CNT_W = 16.
- One sub-module, demux1to2_slice: a combinational 1-bit steer with inputs d and sel and outputs ya = d & ~sel and yb = d & sel.
  - Instantiated N times in a generate loop, with d = data_q[i].
  - Its sel input is driven from the state: 0 in ST_A, 1 in ST_B.
  - Both of its outputs are gated to zero in ST_EMPTY.
- All sequential logic lives in the top module.

## Test plan
- Reset: assert rst_n = 0 mid-hold with a word in ST_A. Required: a_valid, b_valid and in_ready go to 0 and both data buses go to 0 without waiting for a clock edge. After release, in_ready = 1.
- Single word (N = 8): in_data = 8'hA5, s = 1, a_ready = b_ready = 1. Required: next cycle b_valid = 1, b_data = 8'hA5, a_valid = 0, a_data = 8'h00. The cycle after that, state is ST_EMPTY.
- Backpressure: hold 8'h3C for port A with a_ready = 0 for 4 cycles while in_valid = 1. Required: in_ready = 0 and a_data = 8'h3C stable for those 4 cycles; b_ready toggling has no effect; the word is consumed when a_ready rises.
- Alternating stream: 8 words 8'h00..8'h07 with s alternating 0,1,0,1 and both ready high. Required: one word per cycle; even words arrive on A and odd words on B, in order, with no bubbles.
- Simultaneous drain and load: in ST_B with b_ready = 1, in_valid = 1, s = 0, in_data = 8'h11. Required: the old word transfers on B and a_valid = 1 with 8'h11 on the next cycle.
- DEMUX_CNT_EN defined: drive 3 transfers to A and 5 to B. Required: cnt_a = 3, cnt_b = 5. With the counter preloaded near saturation, 70000 transfers on port A leave cnt_a = 16'hFFFF.
